uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx byte transmitter among N_REQ requesters using round-robin arbitration with packet locking. Each requester offers bytes on a valid/ready interface with a last flag. The arbiter grants one requester for a whole packet, so bytes from different requesters never interleave. It then sequences each byte into uart_tx through that block's send_en/send_busy handshake. It sits between the system-side message sources (debug print, status, command reply) and the single uart_tx instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must be at least clog2(N_REQ)
LOCK_TO, 1000, number of idle cycles a locked owner may hold the grant with req_valid low before the lock is forcibly released (minimum 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  N_REQ  per-requester byte valid
req_data  input  N_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  N_REQ  byte is the final byte of its packet
req_ready  output  N_REQ  combinational; a byte transfers when valid and ready are both high
send_en  output  1  one-cycle start pulse to uart_tx
send_data  output  8  byte to uart_tx; held stable from the send_en cycle until the byte completes
send_busy  input  1  uart_tx busy; rises the cycle after send_en is sampled and falls when the stop bit ends
grant_valid  output  1  a packet lock is currently held
grant_id  output  ID_W  owner of the current lock; value is meaningful only while grant_valid is high
lock_abort  output  1  one-cycle pulse when a lock is released by timeout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state is cleared on a clk edge where rst=1.
- Reset values:
  - state=IDLE
  - send_en=0, send_data=0
  - grant_valid=0, grant_id=0
  - lock_abort=0
  - rr_ptr=0, lock timer=0
  - req_ready=0 (because state=IDLE is entered with no acceptance)
- The reset state applies even mid-byte. No recovery of the interrupted byte is attempted, and uart_tx finishes that byte on its own.
- State machine states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Acceptance is allowed only when send_busy=0.
  - If unlocked: select the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - If locked: consider only the owner grant_id.
  - req_ready[sel]=1 in this same cycle. All other ready bits stay 0. In every other state req_ready is all-zero.
  - On transfer, latch req_data[sel] into send_data and go to ISSUE.
- Lock update on transfer:
  - If last=0: grant_valid<=1, grant_id<=sel.
  - If last=1: grant_valid<=0, rr_ptr<=(sel+1) mod N_REQ.
  - A single-byte packet (last=1 while unlocked) never sets grant_valid, but rr_ptr still advances.
- ISSUE: send_en=1 for exactly this cycle, then go to WAIT_ACK.
- WAIT_ACK: stay until send_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until send_busy=0, then go to IDLE.
- Back-to-back throughput: the earliest next acceptance is the cycle after send_busy falls. The minimum per-byte overhead beyond the UART frame is 3 clk cycles.
- Lock timeout:
  - While in IDLE, locked, and req_valid[grant_id]=0, the timer increments each cycle.
  - When the timer reaches LOCK_TO-1: set grant_valid<=0, rr_ptr<=(grant_id+1) mod N_REQ, pulse lock_abort=1 for one cycle, and clear the timer.
  - The timer clears on any transfer and whenever the arbiter is unlocked.
- Simultaneous events:
  - A lock timeout and a request from the owner in the same cycle: the transfer wins and no abort occurs.
  - Requests from non-owners while locked are ignored; they keep waiting.
- send_busy already high in IDLE (for example after a reset mid-frame): no acceptance until it falls.
- Requesters must hold valid, data and last stable until accepted. The arbiter never drops an accepted byte.

Test Plan:
1. Requester 0 only sends 0x55 with last=1 → req_ready[0] high for 1 cycle; send_en pulses 1 cycle later with send_data=0x55; tx line shows 0x55; grant_valid stays 0; rr_ptr=1.
2. After reset, requesters 1 and 2 both send single bytes 0xA1 and 0xB2 with last=1 → 0xA1 is sent first, then 0xB2. Repeat with both requesters 0 and 3 valid while rr_ptr=3 → requester 3 goes first.
3. Requester 0 sends a 3-byte packet 0x10, 0x11, 0x12 (last on 0x12) while requester 1 holds 0x20 valid → transmitted order is 10, 11, 12, 20; grant_valid=1 with grant_id=0 from byte 1 until byte 3 is accepted.
4. LOCK_TO=8: requester 2 sends 1 byte with last=0 then drops valid, while requester 3 is valid → after 8 IDLE cycles lock_abort pulses once and grant_valid falls; requester 3's byte follows.
5. Assert rst during WAIT_DONE → next cycle: state IDLE, send_en=0, grant_valid=0, req_ready=0. A pending request is not accepted until uart_tx's send_busy drops, and is then sent correctly.
6. Owner becomes valid in the exact cycle the timeout would expire → byte is accepted, lock_abort stays 0, lock is retained.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart_tx byte transmitter
// among N_REQ valid/ready byte sources, with a timeout on idle lock owners.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int LOCK_TO = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*8-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 send_en,
  output logic [7:0]           send_data,
  input  logic                 send_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 lock_abort
);

  localparam int TMR_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(LOCK_TO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic              gv_q, gv_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              abort_q, abort_d;

  logic              found;
  logic [ID_W-1:0]   sel;
  logic [7:0]        sel_data;
  logic              sel_last;
  logic              accept;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return ID_W'((int'(id) + 1) % N_REQ);
  endfunction

  // While locked only the owner is eligible; otherwise scan from rr_q upward.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_data = '0;
    sel_last = 1'b0;
    if (gv_q) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ID_W'(i) == gid_q && req_valid[i]) begin
          found = 1'b1;
          sel   = gid_q;
        end
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!found && req_valid[i] && ((int'(rr_q) + k) % N_REQ) == i) begin
            found = 1'b1;
            sel   = ID_W'(i);
          end
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  always_comb begin
    accept = (state_q == IDLE) && !send_busy && found;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (ID_W'(i) == sel);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    tmr_d   = gv_q ? tmr_q : '0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = sel_data;
          state_d = ISSUE;
          tmr_d   = '0;
          if (sel_last) begin
            gv_d = 1'b0;
            rr_d = next_id(sel);
          end else begin
            gv_d  = 1'b1;
            gid_d = sel;
          end
        end else if (gv_q && !found) begin
          // Owner idle: a transfer in this cycle would have taken priority above.
          if (tmr_q == TMR_MAX) begin
            gv_d    = 1'b0;
            rr_d    = next_id(gid_q);
            abort_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  if (send_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!send_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
      rr_q    <= '0;
      tmr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      tmr_q   <= tmr_d;
      abort_q <= abort_d;
    end
  end

  assign send_en     = (state_q == ISSUE);
  assign send_data   = data_q;
  assign grant_valid = gv_q;
  assign grant_id    = gid_q;
  assign lock_abort  = abort_q;

endmodule
